// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one ALU among N_REQ requesters, one op in flight; round-robin by default, fixed priority (lowest index) when ALU_SCHED_FIXED_PRIO_EN is defined
module alu_op_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ALU_LAT = 2,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [3*N_REQ-1:0]       req_op,
  input  logic [WIDTH*N_REQ-1:0]   req_a,
  input  logic [WIDTH*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]         gnt,
  output logic [2:0]               alu_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_start,
  input  logic [WIDTH-1:0]         alu_result,
  output logic                     rsp_valid,
  output logic [IW-1:0]            rsp_id,
  output logic [WIDTH-1:0]         rsp_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] id, id_n, win, j, rsp_id_n;
  logic [N_REQ-1:0] gnt_n;
  logic [2:0] alu_op_n;
  logic [WIDTH-1:0] alu_a_n, alu_b_n, rsp_data_n;
  logic alu_start_n, rsp_valid_n;
`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic [IW-1:0] ptr;
  // round-robin pointer moves just past each winner
  always_ff @(posedge clk)
    if (reset) ptr <= '0;
    else if (state == IDLE && |req) ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
`endif
  // winner among current requests; the search order decides priority
  always_comb begin
    win = '0;
    j = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      j = IW'(i);
`else
      j = IW'((int'(ptr) + i) % N_REQ);
`endif
      win = req[j] ? j : win;
    end
  end
  // next state and next values of every registered output
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    id_n = id;
    gnt_n = '0;
    alu_start_n = 1'b0;
    rsp_valid_n = 1'b0;
    alu_op_n = alu_op;
    alu_a_n = alu_a;
    alu_b_n = alu_b;
    rsp_id_n = rsp_id;
    rsp_data_n = rsp_data;
    case (state)
      IDLE: if (|req) begin
        state_n = ISSUE;
        id_n = win;
        gnt_n = N_REQ'(1) << win;
        alu_start_n = 1'b1;
        alu_op_n = req_op[3*win +: 3];
        alu_a_n = req_a[WIDTH*win +: WIDTH];
        alu_b_n = req_b[WIDTH*win +: WIDTH];
      end
      ISSUE: begin
        state_n = WAIT;
        cnt_n = CW'(ALU_LAT - 1);
      end
      WAIT: if (cnt == '0) begin
        state_n = RESP;
        rsp_valid_n = 1'b1;
        rsp_id_n = id;
        rsp_data_n = alu_result;
      end else cnt_n = cnt - 1'b1;
      RESP: begin
        state_n = IDLE;
        alu_op_n = '0;
        alu_a_n = '0;
        alu_b_n = '0;
      end
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      id <= '0;
      gnt <= '0;
      alu_start <= 1'b0;
      alu_op <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      id <= id_n;
      gnt <= gnt_n;
      alu_start <= alu_start_n;
      alu_op <= alu_op_n;
      alu_a <= alu_a_n;
      alu_b <= alu_b_n;
      rsp_valid <= rsp_valid_n;
      rsp_id <= rsp_id_n;
      rsp_data <= rsp_data_n;
    end
endmodule
